// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
// Detects load-use hazards and EX redirects, selects EX operand forwarding,
// holds the pipeline on slow memory, halts on a memory timeout, and counts
// cycles in which the PC was held.
module hazard_ctrl #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_wb_en,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } state_t;

  localparam int WC_W = $clog2(WAIT_LIMIT + 1);
  // The last MEM_WAIT count before the timeout; one more empty cycle halts.
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_LIMIT - 1);

  state_t          state_q;
  logic [WC_W-1:0] wait_cnt;
  logic            redirect_pend;

  // Destination shadows: EX (_p0), MEM (_p1), WB (_p2).
  logic [4:0] ex_rd_p0;
  logic       ex_wb_en_p0;
  logic       ex_is_load_p0;
  logic [4:0] mem_rd_p1;
  logic       mem_wb_en_p1;
  logic [4:0] wb_rd_p2;
  logic       wb_wb_en_p2;

  logic mem_stall_run;
  logic hold;
  logic halted;
  logic adv;
  logic redir;
  logic load_use;
  logic bubble;
  logic lu_stall;

  // Operand source for one ID register read; the younger EX result wins and
  // x0 is never forwarded. A load in EX cannot forward (its data is not ready).
  function automatic logic [1:0] fwd_sel(
    input logic       used,
    input logic [4:0] rs,
    input logic [4:0] ex_rd,
    input logic       ex_wb_en,
    input logic       ex_is_load,
    input logic [4:0] mem_rd,
    input logic       mem_wb_en
  );
    if (!used || rs == 5'd0) return 2'b00;
    if (rs == ex_rd && ex_wb_en && !ex_is_load) return 2'b01;
    if (rs == mem_rd && mem_wb_en) return 2'b10;
    return 2'b00;
  endfunction

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign state = state_q;

  // Classify the cycle: memory hold, halt, or an advancing cycle in which
  // redirect and load-use are resolved (redirect wins over load-use).
  always_comb begin
    mem_stall_run = (state_q == RUN) && mem_req && !mem_ready;
    hold          = mem_stall_run || ((state_q == MEM_WAIT) && !mem_ready);
    halted        = (state_q == HALT);
    adv           = !hold && !halted;
    redir         = adv && (ex_redirect || redirect_pend);
    load_use      = adv && ex_is_load_p0 && ex_wb_en_p0 && id_valid &&
                    ((id_rs1_used && (id_rs1 == ex_rd_p0)) ||
                     (id_rs2_used && (id_rs2 == ex_rd_p0)));
    bubble        = redir || load_use;
    lu_stall      = load_use && !redir;
  end

  // Pipeline control outputs; all forced low while reset is asserted.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (!reset) begin
      pc_stall     = hold || halted || lu_stall;
      if_id_stall  = hold || halted || lu_stall;
      id_ex_stall  = hold || halted;
      ex_mem_stall = hold || halted;
      if_id_flush  = redir;
      id_ex_bubble = bubble;
    end
  end

  // FSM, wait timer, pending redirect, shadows, forwarding selects, counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt      <= '0;
      redirect_pend <= 1'b0;
      ex_rd_p0      <= 5'd0;
      ex_wb_en_p0   <= 1'b0;
      ex_is_load_p0 <= 1'b0;
      mem_rd_p1     <= 5'd0;
      mem_wb_en_p1  <= 1'b0;
      wb_rd_p2      <= 5'd0;
      wb_wb_en_p2   <= 1'b0;
      fwd_a         <= 2'b00;
      fwd_b         <= 2'b00;
      stall_cnt     <= '0;
    end else begin
      if (pc_stall) stall_cnt <= sat_inc(stall_cnt);

      unique case (state_q)
        RUN: begin
          if (mem_stall_run) begin
            state_q  <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_q <= RUN;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
            if (wait_cnt == WC_LAST) state_q <= HALT;
          end
        end
        default: ;
      endcase

      if (hold && ex_redirect) redirect_pend <= 1'b1;

      // ---- stage boundary: ID -> EX (_p0) -> MEM (_p1) -> WB (_p2) ----
      if (adv) begin
        redirect_pend <= 1'b0;
        mem_rd_p1     <= ex_rd_p0;
        mem_wb_en_p1  <= ex_wb_en_p0;
        wb_rd_p2      <= mem_rd_p1;
        wb_wb_en_p2   <= mem_wb_en_p1;
        if (bubble || !id_valid) begin
          ex_rd_p0      <= 5'd0;
          ex_wb_en_p0   <= 1'b0;
          ex_is_load_p0 <= 1'b0;
          fwd_a         <= 2'b00;
          fwd_b         <= 2'b00;
        end else begin
          ex_rd_p0      <= id_rd;
          ex_wb_en_p0   <= id_wb_en && (id_rd != 5'd0);
          ex_is_load_p0 <= id_is_load;
          fwd_a         <= fwd_sel(id_rs1_used, id_rs1, ex_rd_p0, ex_wb_en_p0,
                                   ex_is_load_p0, mem_rd_p1, mem_wb_en_p1);
          fwd_b         <= fwd_sel(id_rs2_used, id_rs2, ex_rd_p0, ex_wb_en_p0,
                                   ex_is_load_p0, mem_rd_p1, mem_wb_en_p1);
        end
      end
    end
  end

  // x0 is never tracked as a write-back destination in any stage.
  a_wb_no_x0: assert property (@(posedge clk) disable iff (reset)
    wb_wb_en_p2 |-> (wb_rd_p2 != 5'd0));

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: WAIT_LIMIT, default 15, the maximum number of consecutive memory-wait cycles before the FSM enters HALT.
REQ-002 Parameter: CNT_W, default 16, the width of the stall performance counter.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high; sampled on rising edge of clk.
REQ-005 id_valid  in  1  ID stage holds a valid instruction.
REQ-006 id_rs1, id_rs2  in  5 each  source register indices of the ID instruction.
REQ-007 id_rs1_used, id_rs2_used  in  1 each  the ID instruction reads rs1 / rs2.
REQ-008 id_rd  in  5; id_wb_en  in  1; id_is_load  in  1  destination, write-back enable, and load flag of the ID instruction.
REQ-009 ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
REQ-010 mem_req  in  1; mem_ready  in  1  MEM-stage access request and memory completion.
REQ-011 pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the corresponding pipeline register.
REQ-012 if_id_flush, id_ex_bubble  out  1 each  squash IF/ID; insert a NOP into ID/EX.
REQ-013 fwd_a, fwd_b  out  2 each  EX operand select, registered: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
REQ-014 state  out  2  FSM state: 00 RUN, 01 MEM_WAIT, 10 HALT.
REQ-015 stall_cnt  out  CNT_W  saturating count of cycles with pc_stall=1.

Function
REQ-016 Shadow registers SHALL track {rd, wb_en, is_load} for EX, and {rd, wb_en} for MEM and WB; rd=0 SHALL be treated as wb_en=0.
REQ-017 Advance, with no hold active: ex_s <= ID fields if id_valid and no bubble, else cleared; mem_s <= ex_s; wb_s <= mem_s.
REQ-018 Load-use: in RUN, if ex_s.is_load & ex_s.wb_en & id_valid & (rs1_used & rs1==ex_s.rd | rs2_used & rs2==ex_s.rd), then the controller SHALL assert pc_stall=1, if_id_stall=1 and id_ex_bubble=1.
REQ-019 In the load-use case, ex_s SHALL be cleared while mem_s and wb_s advance.
REQ-020 Forwarding, latched when ID advances: fwd_x=01 if rsx_used & rsx==ex_s.rd & ex_s.wb_en & !ex_s.is_load; else 10 if rsx==mem_s.rd & mem_s.wb_en; else 00.
REQ-021 EX/MEM SHALL take priority over MEM/WB, and index 0 SHALL never be forwarded.
REQ-022 On a bubble, fwd_a and fwd_b SHALL load 00.
REQ-023 Redirect: in RUN with no memory hold, ex_redirect=1 SHALL give if_id_flush=1 and id_ex_bubble=1 in the same cycle, with no stall.
REQ-024 When redirect and load-use occur in the same cycle, redirect SHALL win (pc_stall=0).
REQ-025 Memory hold (RUN & mem_req & !mem_ready, or state MEM_WAIT): pc_stall, if_id_stall, id_ex_stall and ex_mem_stall SHALL all be 1, shadows and fwd SHALL hold, and flush/bubble SHALL be 0.
REQ-026 RUN -> MEM_WAIT on mem_req & !mem_ready.
REQ-027 MEM_WAIT -> RUN on mem_ready=1; that cycle SHALL drop the holds and advance the pipeline.
REQ-028 ex_redirect seen during a hold SHALL set redirect_pend; the flush and bubble SHALL be applied in the first advancing cycle, after which redirect_pend clears.
REQ-029 wait_cnt SHALL clear on entering MEM_WAIT and increment each MEM_WAIT cycle without mem_ready; MEM_WAIT -> HALT when wait_cnt reaches WAIT_LIMIT.
REQ-030 In HALT, all four stall outputs SHALL be 1 and flush/bubble SHALL be 0; HALT SHALL exit only via reset.
REQ-031 stall_cnt SHALL increment on every cycle with pc_stall=1, saturate at 2^CNT_W-1, and never wrap.

Reset
REQ-032 With reset=1 at a clock edge: state=RUN, all shadows cleared, fwd_a=fwd_b=00, redirect_pend=0, wait_cnt=0, stall_cnt=0.
REQ-033 With reset=1, all stall, flush and bubble outputs SHALL be 0 combinationally.
REQ-034 Reset asserted mid-MEM_WAIT or in HALT SHALL return to RUN on the next edge, with no pending redirect retained.

Verification
REQ-035 Load-use: lw x5 in EX, ID add x6,x5,x1 (rs1_used=1) -> one cycle of pc_stall=if_id_stall=id_ex_bubble=1; next cycle add advances with fwd_a=10, and stall_cnt=1.
REQ-036 Forwarding priority: add x3 in MEM-bound EX and sub x3 in MEM, ID uses rs2=x3 -> fwd_b=01; with rd=x0 in both -> fwd_b=00.
REQ-037 Redirect plus load-use in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_stall=0.
REQ-038 mem_req=1 with mem_ready low for 3 cycles, ex_redirect pulsed in wait cycle 2 -> state=01 for 3 cycles, all stalls=1; on the mem_ready cycle, if_id_flush=1 and id_ex_bubble=1.
REQ-039 mem_ready held low for 16 cycles (WAIT_LIMIT=15) -> state=10 and all stalls remain 1; reset pulse -> state=00, stall_cnt=0.
